// File: rtl/bandgap_trim_ctrl.sv
// Bandgap reference sequencer: power-up, SAR trim calibration against an
// external comparator, buffer op-amp enable, then hold ready.
module bandgap_trim_ctrl #(
  parameter int TRIM_W      = 6,
  parameter int STARTUP_TMO = 256,
  parameter int CMP_WAIT    = 16,
  parameter int BUF_WAIT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              cal_bypass,
  input  logic [TRIM_W-1:0] trim_in,
  input  logic              pgood,
  input  logic              cmp_hi,
  output logic              bg_en,
  output logic              buf_en,
  output logic [TRIM_W-1:0] trim,
  output logic              busy,
  output logic              ready,
  output logic              fail
);

  localparam int CNT_MAX = (STARTUP_TMO > CMP_WAIT)
                         ? ((STARTUP_TMO > BUF_WAIT) ? STARTUP_TMO : BUF_WAIT)
                         : ((CMP_WAIT > BUF_WAIT) ? CMP_WAIT : BUF_WAIT);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;

  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [BIT_W-1:0]  bit_t;
  typedef logic [TRIM_W-1:0] trim_t;

  localparam cnt_t  STARTUP_LAST = cnt_t'(STARTUP_TMO - 1);
  localparam cnt_t  CMP_LAST     = cnt_t'(CMP_WAIT - 1);
  localparam cnt_t  BUF_LAST     = cnt_t'(BUF_WAIT - 1);
  localparam bit_t  BIT_TOP      = bit_t'(TRIM_W - 1);
  localparam trim_t TRIM_MID     = trim_t'(1) << (TRIM_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STARTUP,
    S_SWEEP,
    S_BUF_SETTLE,
    S_READY,
    S_FAIL
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  bit_t   bit_q, bit_d;
  logic   byp_q, byp_d;
  trim_t  tin_q, tin_d;
  trim_t  trim_q, trim_d;

  logic   bg_en_q, bg_en_d;
  logic   buf_en_q, buf_en_d;
  logic   busy_q, busy_d;
  logic   ready_q, ready_d;
  logic   fail_q, fail_d;

  trim_t  bit_mask;
  assign bit_mask = trim_t'(1) << bit_q;

  // NOTE: every register uses non-blocking assignments so all flops update
  // from the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byp_q    <= 1'b0;
      tin_q    <= '0;
      trim_q   <= '0;
      bg_en_q  <= 1'b0;
      buf_en_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byp_q    <= byp_d;
      tin_q    <= tin_d;
      trim_q   <= trim_d;
      bg_en_q  <= bg_en_d;
      buf_en_q <= buf_en_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      fail_q   <= fail_d;
    end
  end

  // NOTE: every signal gets its hold value first so no path through the case
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byp_d   = byp_q;
    tin_d   = tin_q;
    trim_d  = trim_q;

    if (stop) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_FAIL: begin
          if (start) begin
            state_d = S_STARTUP;
            cnt_d   = '0;
            byp_d   = cal_bypass;
            tin_d   = trim_in;
          end
        end

        S_STARTUP: begin
          if (pgood) begin
            cnt_d = '0;
            if (byp_q) begin
              state_d = S_BUF_SETTLE;
              trim_d  = tin_q;
            end else begin
              state_d = S_SWEEP;
              trim_d  = TRIM_MID;
              bit_d   = BIT_TOP;
            end
          end else if (cnt_q == STARTUP_LAST) begin
            state_d = S_FAIL;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        // Each bit: clear it if the comparator says too high, then probe the next.
        S_SWEEP: begin
          if (!pgood) begin
            state_d = S_FAIL;
          end else if (cnt_q == CMP_LAST) begin
            cnt_d  = '0;
            trim_d = (trim_q & ~(cmp_hi ? bit_mask : '0)) | (bit_mask >> 1);
            if (bit_q != '0) begin
              bit_d = bit_q - bit_t'(1);
            end else begin
              state_d = S_BUF_SETTLE;
            end
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        S_BUF_SETTLE: begin
          if (!pgood) begin
            state_d = S_FAIL;
          end else if (cnt_q == BUF_LAST) begin
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + cnt_t'(1);
          end
        end

        S_READY: begin
          if (!pgood) state_d = S_FAIL;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    bg_en_d  = 1'b0;
    buf_en_d = 1'b0;
    busy_d   = 1'b0;
    ready_d  = 1'b0;
    fail_d   = 1'b0;
    unique case (state_d)
      S_STARTUP: begin
        bg_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_SWEEP: begin
        bg_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_BUF_SETTLE: begin
        bg_en_d  = 1'b1;
        buf_en_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_READY: begin
        bg_en_d  = 1'b1;
        buf_en_d = 1'b1;
        ready_d  = 1'b1;
      end
      S_FAIL:  fail_d = 1'b1;
      default: ;
    endcase
  end

  assign bg_en  = bg_en_q;
  assign buf_en = buf_en_q;
  assign trim   = trim_q;
  assign busy   = busy_q;
  assign ready  = ready_q;
  assign fail   = fail_q;

endmodule

// File: tb/tb_bandgap_trim_ctrl.sv
// Bench for bandgap_trim_ctrl: phase/timeline reference model compared every
// cycle, plus directed scenarios with hand-computed latencies and trim codes.
module tb_bandgap_trim_ctrl;

  localparam int TRIM_W      = 6;
  localparam int STARTUP_TMO = 8;
  localparam int CMP_WAIT    = 4;
  localparam int BUF_WAIT    = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cal_bypass = 1'b0;
  logic [5:0] trim_in = '0;
  logic       pgood = 1'b0;
  logic       cmp_hi;
  logic       bg_en, buf_en, busy, ready, fail;
  logic [5:0] trim;

  int thr     = 'h2B;  // comparator threshold: cmp_hi = trim > thr
  int pg_mode = 2;     // 0 forced low, 1 forced high, 2 rises 3 cycles after bg_en
  int pg_cnt  = 0;
  int total   = 0;
  int bad     = 0;
  bit cmp_en  = 1'b0;

  always #5 clk = ~clk;

  assign cmp_hi = (int'(trim) > thr);

  bandgap_trim_ctrl #(
    .TRIM_W     (TRIM_W),
    .STARTUP_TMO(STARTUP_TMO),
    .CMP_WAIT   (CMP_WAIT),
    .BUF_WAIT   (BUF_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .cal_bypass(cal_bypass),
    .trim_in   (trim_in),
    .pgood     (pgood),
    .cmp_hi    (cmp_hi),
    .bg_en     (bg_en),
    .buf_en    (buf_en),
    .trim      (trim),
    .busy      (busy),
    .ready     (ready),
    .fail      (fail)
  );

  // Analog stand-in for the bandgap power-good.
  always @(negedge clk) begin
    #1;
    case (pg_mode)
      0: begin pg_cnt = 0; pgood = 1'b0; end
      1: begin pg_cnt = 0; pgood = 1'b1; end
      default: begin
        if (bg_en === 1'b1) pg_cnt = pg_cnt + 1;
        else pg_cnt = 0;
        pgood = (pg_cnt >= 3);
      end
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {P_OFF, P_WAKE, P_CAL, P_SETTLE, P_ON, P_ERR} phase_e;

  phase_e     m_phase;
  int         m_t;
  logic [5:0] m_trim;
  bit         m_byp;
  logic [5:0] m_tin;

  // SAR probe after t cycles of calibration: top bits already match the
  // answer, the next bit down is being tried.
  function automatic logic [5:0] sar_trim(input int t, input int fin);
    int j;
    logic [5:0] top;
    j = t / CMP_WAIT;
    if (j >= TRIM_W) return 6'(fin);
    top = 6'(((1 << j) - 1) << (TRIM_W - j));
    return (6'(fin) & top) | 6'(1 << (TRIM_W - 1 - j));
  endfunction

  always @(posedge clk or posedge rst) begin : model
    phase_e     np;
    int         nt;
    int         fin;
    logic [5:0] ntrim;
    bit         nbyp;
    logic [5:0] ntin;
    if (rst) begin
      m_phase <= P_OFF;
      m_t     <= 0;
      m_trim  <= '0;
      m_byp   <= 1'b0;
      m_tin   <= '0;
    end else begin
      np    = m_phase;
      nt    = m_t;
      ntrim = m_trim;
      nbyp  = m_byp;
      ntin  = m_tin;
      fin   = (thr < 0) ? 0 : ((thr > 63) ? 63 : thr);
      if (stop) begin
        np = P_OFF;
      end else begin
        case (m_phase)
          P_OFF, P_ERR: if (start) begin
            np = P_WAKE; nt = 0; nbyp = cal_bypass; ntin = trim_in;
          end
          P_WAKE: begin
            if (pgood) begin
              nt = 0;
              if (m_byp) begin np = P_SETTLE; ntrim = m_tin; end
              else begin np = P_CAL; ntrim = sar_trim(0, fin); end
            end else if (m_t >= STARTUP_TMO - 1) np = P_ERR;
            else nt = m_t + 1;
          end
          P_CAL: begin
            if (!pgood) np = P_ERR;
            else begin
              nt = m_t + 1;
              if (nt == TRIM_W * CMP_WAIT) begin np = P_SETTLE; nt = 0; ntrim = 6'(fin); end
              else ntrim = sar_trim(nt, fin);
            end
          end
          P_SETTLE: begin
            if (!pgood) np = P_ERR;
            else begin
              nt = m_t + 1;
              if (nt == BUF_WAIT) np = P_ON;
            end
          end
          P_ON: if (!pgood) np = P_ERR;
          default: ;
        endcase
      end
      m_phase <= np;
      m_t     <= nt;
      m_trim  <= ntrim;
      m_byp   <= nbyp;
      m_tin   <= ntin;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [10:0] e;
      e[10]  = (m_phase inside {P_WAKE, P_CAL, P_SETTLE, P_ON});
      e[9]   = (m_phase inside {P_SETTLE, P_ON});
      e[8]   = (m_phase inside {P_WAKE, P_CAL, P_SETTLE});
      e[7]   = (m_phase == P_ON);
      e[6]   = (m_phase == P_ERR);
      e[5:0] = m_trim;
      check("model_cmp", 32'({bg_en, buf_en, busy, ready, fail, trim}), 32'(e));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input bit byp, input logic [5:0] tin);
    cal_bypass = byp;
    trim_in    = tin;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  // 0 buf_en, 1 ready, 2 fail, 3 sweep entry (busy with trim at midscale)
  task automatic wait_until(input string name, input int code, input int max_cyc, output int n);
    bit hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < max_cyc) begin
      @(negedge clk);
      n = n + 1;
      case (code)
        0:       hit = (buf_en === 1'b1);
        1:       hit = (ready === 1'b1);
        2:       hit = (fail === 1'b1);
        default: hit = (busy === 1'b1 && trim === 6'h20);
      endcase
    end
    if (!hit) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL timeout %s: got no event within %0d cycles", name, max_cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({bg_en, buf_en, busy, ready, fail, trim}), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Normal calibration, threshold 0x2B
    thr = 'h2B; pg_mode = 2;
    pulse_start(1'b0, 6'h00);
    check("bg_en_after_start", 32'(bg_en), 32'h1);
    wait_until("sweep_entry", 3, 20, n);
    wait_until("sweep_done", 0, 40, n);
    check("sweep_len", n, 24);
    check("trim_at_buf", 32'(trim), 32'h2B);
    check("busy_in_settle", 32'(busy), 32'h1);
    wait_until("ready_rise", 1, 20, n);
    check("ready_lat", n, 5);
    check("busy_at_ready", 32'(busy), 32'h0);
    pulse_start(1'b1, 6'h07);
    @(negedge clk);
    check("ready_ignores_start", 32'({ready, trim}), 32'({1'b1, 6'h2B}));

    // Power-good never arrives, then a retry succeeds
    pg_mode = 0;
    pulse_stop();
    check("idle_after_stop", 32'({bg_en, busy, ready}), 32'h0);
    @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("startup_timeout", 2, 20, n);
    check("startup_tmo_len", n, 8);
    check("bg_en_in_fail", 32'(bg_en), 32'h0);
    pg_mode = 1;
    @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("retry_ready", 1, 60, n);
    check("retry_lat", n, 30);
    check("retry_trim", 32'(trim), 32'h2B);

    // Bypass with manual trim; trim_in changes after start must not matter
    pulse_stop();
    pg_mode = 2;
    repeat (2) @(negedge clk);
    pulse_start(1'b1, 6'h15);
    trim_in = 6'h0A;
    wait_until("byp_buf_en", 0, 20, n);
    check("byp_pgood_lat", n, 3);
    check("byp_trim", 32'(trim), 32'h15);
    wait_until("byp_ready", 1, 20, n);
    check("byp_ready_lat", n, 5);

    // Power-good drop in READY, then start+stop together
    pg_mode = 0;
    wait_until("pg_drop_fail", 2, 5, n);
    check("pg_drop_lat", n, 1);
    check("fail_outputs", 32'({bg_en, buf_en, ready, trim}), 32'({3'b000, 6'h15}));
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'({fail, busy, bg_en, trim}), 32'({3'b000, 6'h15}));

    // Comparator always high
    pg_mode = 2; thr = -1;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("sweep_entry_hi", 3, 20, n);
    wait_until("sweep_done_hi", 0, 40, n);
    check("cmp_always_hi_trim", 32'(trim), 32'h00);

    // Comparator always low
    pulse_stop();
    thr = 63;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("sweep_entry_lo", 3, 20, n);
    wait_until("sweep_done_lo", 0, 40, n);
    check("cmp_always_lo_trim", 32'(trim), 32'h3F);

    // Stop in the middle of the sweep
    pulse_stop();
    thr = 'h2B;
    repeat (2) @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("sweep_entry_stop", 3, 20, n);
    repeat (7) @(negedge clk);
    pulse_stop();
    check("stop_in_sweep", 32'({bg_en, buf_en, busy, fail}), 32'h0);

    // Asynchronous reset mid-sweep, observed before the next clock edge
    @(negedge clk);
    pulse_start(1'b0, 6'h00);
    wait_until("sweep_entry_rst", 3, 20, n);
    repeat (5) @(negedge clk);
    check("busy_before_rst", 32'(busy), 32'h1);
    #1 rst = 1'b1;
    #1 check("async_reset", 32'({bg_en, buf_en, busy, ready, fail, trim}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
